// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multicycle control FSM for the `processing` datapath. Decodes the IR and the
// ALU status flags and drives every datapath control strobe/select. Memory
// wait states are absorbed by an internal down-counter loaded on entry to the
// FETCH, LD_WAIT and EXC_WAIT states.
//
// Optional feature (compile-time macro MC_OVERFLOW_EXC_EN):
//   defined   -> ARITH_COMPL of an overflowing R-type ADD/SUB or ADDI
//                suppresses the register write and traps to EXC_OVERFLOW.
//   undefined -> alu_overflow is ignored and the write always happens.
//
// Parameters:
//   IMEM_WAIT  extra cycles between IMemRead and IR capture (0..15)
//   DMEM_WAIT  extra cycles for data/exception-vector reads (0..15)
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   instruction[31:0]      IR contents
//   alu_equal/greater/less/overflow   ALU status flags
//   PCWrite, PCWriteCond, PCWriteState, PCSource[1:0]   PC control
//   ALUSrcA/ALUSrcB/MemToReg/LoadSplice/StoreSplice[1:0], ALUOp[3:0]
//   LoadAOut, RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR, IMemRead, IRWrite
//   IntCause, CauseWrite, EPCWrite, DataMemSrc   exception control
//   Halted                 sticky halt indicator
//   state_out[4:0]         current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_control_unit #(
  parameter int IMEM_WAIT = 1,
  parameter int DMEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  input  logic        alu_overflow,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCWriteState,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  MemToReg,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        IntCause,
  output logic        CauseWrite,
  output logic        EPCWrite,
  output logic        DataMemSrc,
  output logic        Halted,
  output logic [4:0]  state_out
);

  // Opcodes
  localparam logic [6:0] OP_LD        = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S    = 7'b0100011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_TYPE_R    = 7'b0110011;
  localparam logic [6:0] OP_TYPE_U    = 7'b0110111;
  localparam logic [6:0] OP_TYPE_SB   = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BREAK     = 7'b1110011;

  localparam logic [31:0] HALT_WORD = 32'h00100073;

  // funct3 codes
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_SD   = 3'b011;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRI  = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [5:0] F6_SRAI = 6'b010000;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_SUM  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_LESS = 4'd7;
  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_SHRA = 4'd10;

  // Mux selects
  localparam logic [1:0] ALA_PC      = 2'd0;
  localparam logic [1:0] ALA_A       = 2'd1;
  localparam logic [1:0] ALA_ZERO    = 2'd2;
  localparam logic [1:0] ALB_B       = 2'd0;
  localparam logic [1:0] ALB_CONST4  = 2'd1;
  localparam logic [1:0] ALB_IMM     = 2'd2;
  localparam logic [1:0] ALB_IMM2    = 2'd3;
  localparam logic [1:0] PC_ALU_OUT  = 2'd0;
  localparam logic [1:0] PC_ALU_REG  = 2'd1;
  localparam logic [1:0] PC_EXC_VEC  = 2'd2;
  localparam logic [1:0] FW_ALU_OUT  = 2'd0;
  localparam logic [1:0] FW_MDR      = 2'd1;
  localparam logic [1:0] FW_PC_4     = 2'd2;

  // Splice codes
  localparam logic [1:0] SPL_LD  = 2'd0;
  localparam logic [1:0] SPL_LW  = 2'd1;
  localparam logic [1:0] SPL_LH  = 2'd2;
  localparam logic [1:0] SPL_LBU = 2'd3;
  localparam logic [1:0] SPL_SD  = 2'd0;
  localparam logic [1:0] SPL_SW  = 2'd1;
  localparam logic [1:0] SPL_SH  = 2'd2;
  localparam logic [1:0] SPL_SB  = 2'd3;

  localparam int WAIT_MAX = (IMEM_WAIT > DMEM_WAIT) ? IMEM_WAIT : DMEM_WAIT;
  localparam int CNT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [4:0] {
    S_START        = 5'd0,
    S_FETCH        = 5'd1,
    S_DECODE       = 5'd2,
    S_MEM_ADDR     = 5'd3,
    S_LD_WAIT      = 5'd4,
    S_WRITE_BACK   = 5'd5,
    S_STORE        = 5'd6,
    S_EXEC_R       = 5'd7,
    S_EXEC_I       = 5'd8,
    S_EXEC_U       = 5'd9,
    S_ARITH_COMPL  = 5'd10,
    S_BRANCH       = 5'd11,
    S_JUMP_LINK    = 5'd12,
    S_JAL_COMPL    = 5'd13,
    S_JALR_COMPL   = 5'd14,
    S_BRK          = 5'd15,
    S_EXC_OPCODE   = 5'd16,
    S_EXC_OVERFLOW = 5'd17,
    S_EXC_WAIT     = 5'd18,
    S_HALT         = 5'd19
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] funct6;
  logic       funct7_b5;
  logic       branch_cond;
  logic       ovf_trap;
  logic       wait_done;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct6    = instruction[31:26];
  assign funct7_b5 = instruction[30];
  assign wait_done = (cnt_q == '0);

`ifdef MC_OVERFLOW_EXC_EN
  // Only signed add/subtract style instructions can raise an overflow trap.
  assign ovf_trap = alu_overflow &&
                    (((opcode == OP_TYPE_R) || (opcode == OP_IMM_ARITH)) &&
                     (funct3 == F3_ADD));
`else
  logic unused_overflow;
  assign unused_overflow = alu_overflow;
  assign ovf_trap        = 1'b0;
`endif

  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      F3_BEQ:  branch_cond = alu_equal;
      F3_BNE:  branch_cond = ~alu_equal;
      F3_BLT:  branch_cond = alu_less;
      F3_BGE:  branch_cond = alu_greater | alu_equal;
      default: branch_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. Wait states hold until the counter reaches zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_TYPE_S: state_d = S_MEM_ADDR;
          OP_IMM_ARITH:     state_d = S_EXEC_I;
          OP_TYPE_R:        state_d = S_EXEC_R;
          OP_TYPE_U:        state_d = S_EXEC_U;
          OP_TYPE_SB:       state_d = S_BRANCH;
          OP_JAL, OP_JALR:  state_d = S_JUMP_LINK;
          OP_BREAK:         state_d = S_BRK;
          default:          state_d = S_EXC_OPCODE;
        endcase
      end
      S_MEM_ADDR:    state_d = (opcode == OP_LD) ? S_LD_WAIT : S_STORE;
      S_LD_WAIT:     if (wait_done) state_d = S_WRITE_BACK;
      S_WRITE_BACK:  state_d = S_FETCH;
      S_STORE:       state_d = S_FETCH;
      S_EXEC_R:      state_d = S_ARITH_COMPL;
      S_EXEC_I:      state_d = S_ARITH_COMPL;
      S_EXEC_U:      state_d = S_ARITH_COMPL;
      S_ARITH_COMPL: state_d = ovf_trap ? S_EXC_OVERFLOW : S_FETCH;
      S_BRANCH:      state_d = S_FETCH;
      S_JUMP_LINK:   state_d = (opcode == OP_JALR) ? S_JALR_COMPL : S_JAL_COMPL;
      S_JAL_COMPL:   state_d = S_FETCH;
      S_JALR_COMPL:  state_d = S_FETCH;
      S_BRK:         state_d = (instruction == HALT_WORD) ? S_HALT : S_EXC_OPCODE;
      S_EXC_OPCODE:  state_d = S_EXC_WAIT;
      S_EXC_OVERFLOW: state_d = S_EXC_WAIT;
      S_EXC_WAIT:    if (wait_done) state_d = S_FETCH;
      S_HALT:        state_d = S_HALT;
      default:       state_d = S_FETCH;
    endcase
  end

  // Counter reloads whenever a waiting state is newly entered, so the first
  // cycle in that state already sees the full wait count.
  always_comb begin
    cnt_d = wait_done ? '0 : cnt_q - 1'b1;
    if (state_d != state_q) begin
      case (state_d)
        S_FETCH:               cnt_d = CNT_W'(IMEM_WAIT);
        S_LD_WAIT, S_EXC_WAIT: cnt_d = CNT_W'(DMEM_WAIT);
        default:               ;
      endcase
    end
  end

  // Moore outputs; reset forces the idle values combinationally.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'd0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    MemToReg    = 2'd0;
    LoadSplice  = 2'd0;
    StoreSplice = 2'd0;
    ALUOp       = ALU_SUM;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    DMemOp      = 1'b0;
    LoadMDR     = 1'b0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    IntCause    = 1'b0;
    CauseWrite  = 1'b0;
    EPCWrite    = 1'b0;
    DataMemSrc  = 1'b0;
    Halted      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IMemRead = 1'b1;
          if (wait_done) begin
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            PCSource = PC_ALU_OUT;
            ALUSrcA  = ALA_PC;
            ALUSrcB  = ALB_CONST4;
            ALUOp    = ALU_SUM;
          end
        end
        S_DECODE: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          LoadAOut = 1'b1;
          ALUSrcA  = ALA_PC;
          ALUSrcB  = ALB_IMM2;
          ALUOp    = ALU_SUM;
        end
        S_MEM_ADDR: begin
          ALUSrcA  = ALA_A;
          ALUSrcB  = ALB_IMM;
          ALUOp    = ALU_SUM;
          LoadAOut = 1'b1;
        end
        S_LD_WAIT: begin
          DMemOp  = 1'b0;
          LoadMDR = wait_done;
        end
        S_WRITE_BACK: begin
          RegWrite = 1'b1;
          MemToReg = FW_MDR;
          case (funct3)
            F3_LW:   LoadSplice = SPL_LW;
            F3_LH:   LoadSplice = SPL_LH;
            F3_LBU:  LoadSplice = SPL_LBU;
            F3_LD:   LoadSplice = SPL_LD;
            default: LoadSplice = SPL_LD;
          endcase
        end
        S_STORE: begin
          DMemOp = 1'b1;
          case (funct3)
            F3_SW:   StoreSplice = SPL_SW;
            F3_SH:   StoreSplice = SPL_SH;
            F3_SB:   StoreSplice = SPL_SB;
            F3_SD:   StoreSplice = SPL_SD;
            default: StoreSplice = SPL_SD;
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA  = ALA_A;
          ALUSrcB  = ALB_B;
          LoadAOut = 1'b1;
          case (funct3)
            F3_ADD:  ALUOp = funct7_b5 ? ALU_SUB : ALU_SUM;
            F3_SLT:  ALUOp = ALU_LESS;
            F3_AND:  ALUOp = ALU_AND;
            default: ALUOp = ALU_SUM;
          endcase
        end
        S_EXEC_I: begin
          ALUSrcA  = ALA_A;
          ALUSrcB  = ALB_IMM;
          LoadAOut = 1'b1;
          case (funct3)
            F3_ADD:  ALUOp = ALU_SUM;
            F3_SLT:  ALUOp = ALU_LESS;
            F3_SLLI: ALUOp = ALU_SHL;
            F3_SRI:  ALUOp = (funct6 == F6_SRAI) ? ALU_SHRA : ALU_SHR;
            default: ALUOp = ALU_SUM;
          endcase
        end
        S_EXEC_U: begin
          ALUSrcA  = ALA_ZERO;
          ALUSrcB  = ALB_IMM;
          ALUOp    = ALU_SUM;
          LoadAOut = 1'b1;
        end
        S_ARITH_COMPL: begin
          MemToReg = FW_ALU_OUT;
          RegWrite = ~ovf_trap;
        end
        S_BRANCH: begin
          PCWriteCond = 1'b1;
          PCSource    = PC_ALU_REG;
          ALUSrcA     = ALA_A;
          ALUSrcB     = ALB_B;
          ALUOp       = ALU_SUB;
        end
        S_JUMP_LINK: begin
          RegWrite = 1'b1;
          MemToReg = FW_PC_4;
        end
        S_JAL_COMPL: begin
          PCWrite  = 1'b1;
          PCSource = PC_ALU_REG;
        end
        S_JALR_COMPL: begin
          PCWrite  = 1'b1;
          PCSource = PC_ALU_OUT;
          ALUSrcA  = ALA_A;
          ALUSrcB  = ALB_IMM2;
          ALUOp    = ALU_SUM;
        end
        S_EXC_OPCODE, S_EXC_OVERFLOW: begin
          IntCause   = (state_q == S_EXC_OVERFLOW);
          CauseWrite = 1'b1;
          EPCWrite   = 1'b1;
          DataMemSrc = 1'b1;
          DMemOp     = 1'b0;
          ALUSrcA    = ALA_PC;
          ALUSrcB    = ALB_CONST4;
          ALUOp      = ALU_SUB;
        end
        S_EXC_WAIT: begin
          DataMemSrc = 1'b1;
          if (wait_done) begin
            PCWrite  = 1'b1;
            PCSource = PC_EXC_VEC;
          end
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign PCWriteState = PCWrite | (PCWriteCond & branch_cond);
  assign state_out    = reset ? 5'd0 : 5'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
// Self-checking bench for mc_control_unit (IMEM_WAIT=1, DMEM_WAIT=2). A
// reference model turns each instruction into the expected per-cycle walk
// through the machine, which is compared against the DUT cycle by cycle.
// Honors MC_OVERFLOW_EXC_EN in the model the same way the design does.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

  localparam int IMEM_W = 1;
  localparam int DMEM_W = 2;

  localparam int ST_START = 0,  ST_FETCH = 1,  ST_DECODE = 2,  ST_MEM_ADDR = 3;
  localparam int ST_LD_WAIT = 4, ST_WB = 5,    ST_STORE = 6,   ST_EXEC_R = 7;
  localparam int ST_EXEC_I = 8, ST_EXEC_U = 9, ST_ARITH = 10,  ST_BRANCH = 11;
  localparam int ST_JL = 12,    ST_JAL = 13,   ST_JALR = 14,   ST_BRK = 15;
  localparam int ST_EXC_OP = 16, ST_EXC_OV = 17, ST_EXC_WAIT = 18, ST_HALT = 19;

  localparam int A_AND = 0, A_SUM = 2, A_SUB = 6, A_LESS = 7;
  localparam int A_SHL = 8, A_SHR = 9, A_SHRA = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_equal, alu_greater, alu_less, alu_overflow;
  logic        PCWrite, PCWriteCond, PCWriteState;
  logic [1:0]  PCSource, ALUSrcA, ALUSrcB, MemToReg, LoadSplice, StoreSplice;
  logic [3:0]  ALUOp;
  logic        LoadAOut, RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR;
  logic        IMemRead, IRWrite, IntCause, CauseWrite, EPCWrite, DataMemSrc;
  logic        Halted;
  logic [4:0]  state_out;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    int st;
    bit irw;
    bit pcws;
    bit rw;
    bit mdr;
    int alu;
    int spl;
    int cause;
  } rec_t;

  rec_t trace[$];

  mc_control_unit #(.IMEM_WAIT(IMEM_W), .DMEM_WAIT(DMEM_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_equal(alu_equal), .alu_greater(alu_greater), .alu_less(alu_less),
    .alu_overflow(alu_overflow),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteState(PCWriteState),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .MemToReg(MemToReg), .LoadSplice(LoadSplice), .StoreSplice(StoreSplice),
    .ALUOp(ALUOp), .LoadAOut(LoadAOut), .RegWrite(RegWrite),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .DMemOp(DMemOp),
    .LoadMDR(LoadMDR), .IMemRead(IMemRead), .IRWrite(IRWrite),
    .IntCause(IntCause), .CauseWrite(CauseWrite), .EPCWrite(EPCWrite),
    .DataMemSrc(DataMemSrc), .Halted(Halted), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input bit eq,
                               input bit gt, input bit lt, input bit ovf);
    instruction  = ins;
    alu_equal    = eq;
    alu_greater  = gt;
    alu_less     = lt;
    alu_overflow = ovf;
  endtask

  function automatic void pushRec(int st, bit irw, bit pcws, bit rw, bit mdr,
                                  int alu, int spl, int cause);
    rec_t r;
    r.st = st; r.irw = irw; r.pcws = pcws; r.rw = rw; r.mdr = mdr;
    r.alu = alu; r.spl = spl; r.cause = cause;
    trace.push_back(r);
  endfunction

  function automatic void addException(int cause);
    pushRec(cause ? ST_EXC_OV : ST_EXC_OP, 0, 0, 0, 0, A_SUB, -1, cause);
    for (int i = 0; i <= DMEM_W; i++)
      pushRec(ST_EXC_WAIT, 0, (i == DMEM_W), 0, 0, -1, -1, -1);
  endfunction

  // Expected cycle-by-cycle walk for one instruction, starting at FETCH.
  function automatic void buildTrace(logic [31:0] ins, bit eq, bit gt, bit lt, bit ovf);
    logic [6:0] op;
    logic [2:0] f3;
    int         aluv, splv;
    bit         trap;
    op = ins[6:0];
    f3 = ins[14:12];
    trace.delete();
    for (int i = 0; i <= IMEM_W; i++)
      pushRec(ST_FETCH, (i == IMEM_W), (i == IMEM_W), 0, 0, -1, -1, -1);
    pushRec(ST_DECODE, 0, 0, 0, 0, A_SUM, -1, -1);
    trap = 1'b0;
`ifdef MC_OVERFLOW_EXC_EN
    trap = ovf && (op == 7'h33 || op == 7'h13) && (f3 == 3'd0);
`endif
    case (op)
      7'h03: begin
        case (f3)
          3'd2: splv = 1;
          3'd1: splv = 2;
          3'd4: splv = 3;
          default: splv = 0;
        endcase
        pushRec(ST_MEM_ADDR, 0, 0, 0, 0, A_SUM, -1, -1);
        for (int i = 0; i <= DMEM_W; i++)
          pushRec(ST_LD_WAIT, 0, 0, 0, (i == DMEM_W), -1, -1, -1);
        pushRec(ST_WB, 0, 0, 1, 0, -1, splv, -1);
      end
      7'h23: begin
        case (f3)
          3'd2: splv = 1;
          3'd1: splv = 2;
          3'd0: splv = 3;
          default: splv = 0;
        endcase
        pushRec(ST_MEM_ADDR, 0, 0, 0, 0, A_SUM, -1, -1);
        pushRec(ST_STORE, 0, 0, 0, 0, -1, splv, -1);
      end
      7'h33, 7'h13, 7'h37: begin
        if (op == 7'h33) begin
          if (f3 == 3'd0)      aluv = ins[30] ? A_SUB : A_SUM;
          else if (f3 == 3'd2) aluv = A_LESS;
          else if (f3 == 3'd7) aluv = A_AND;
          else                 aluv = A_SUM;
          pushRec(ST_EXEC_R, 0, 0, 0, 0, aluv, -1, -1);
        end else if (op == 7'h13) begin
          if (f3 == 3'd2)      aluv = A_LESS;
          else if (f3 == 3'd1) aluv = A_SHL;
          else if (f3 == 3'd5) aluv = (ins[31:26] == 6'b010000) ? A_SHRA : A_SHR;
          else                 aluv = A_SUM;
          pushRec(ST_EXEC_I, 0, 0, 0, 0, aluv, -1, -1);
        end else begin
          pushRec(ST_EXEC_U, 0, 0, 0, 0, A_SUM, -1, -1);
        end
        pushRec(ST_ARITH, 0, 0, !trap, 0, -1, -1, -1);
        if (trap) addException(1);
      end
      7'h63: begin
        bit taken;
        case (f3)
          3'd0: taken = eq;
          3'd1: taken = !eq;
          3'd4: taken = lt;
          3'd5: taken = gt || eq;
          default: taken = 1'b0;
        endcase
        pushRec(ST_BRANCH, 0, taken, 0, 0, A_SUB, -1, -1);
      end
      7'h6f: begin
        pushRec(ST_JL, 0, 0, 1, 0, -1, -1, -1);
        pushRec(ST_JAL, 0, 1, 0, 0, -1, -1, -1);
      end
      7'h67: begin
        pushRec(ST_JL, 0, 0, 1, 0, -1, -1, -1);
        pushRec(ST_JALR, 0, 1, 0, 0, A_SUM, -1, -1);
      end
      7'h73: begin
        pushRec(ST_BRK, 0, 0, 0, 0, -1, -1, -1);
        if (ins == 32'h00100073) pushRec(ST_HALT, 0, 0, 0, 0, -1, -1, -1);
        else                     addException(0);
      end
      default: addException(0);
    endcase
  endfunction

  // Runs up to 'limit' cycles of one instruction; enters and leaves at
  // 1 time unit after a rising edge.
  task automatic runInstr(input logic [31:0] ins, input bit eq, input bit gt,
                          input bit lt, input bit ovf, input int limit);
    applyStimulus(ins, eq, gt, lt, ovf);
    buildTrace(ins, eq, gt, lt, ovf);
    for (int i = 0; i < trace.size() && i < limit; i++) begin
      #1;
      checkOutput("state", 32'(state_out), trace[i].st);
      checkOutput("IRWrite", 32'(IRWrite), 32'(trace[i].irw));
      checkOutput("PCWriteState", 32'(PCWriteState), 32'(trace[i].pcws));
      checkOutput("RegWrite", 32'(RegWrite), 32'(trace[i].rw));
      checkOutput("LoadMDR", 32'(LoadMDR), 32'(trace[i].mdr));
      checkOutput("Halted", 32'(Halted), 32'(trace[i].st == ST_HALT));
      if (trace[i].alu >= 0) checkOutput("ALUOp", 32'(ALUOp), trace[i].alu);
      if (trace[i].spl >= 0 && trace[i].st == ST_WB)
        checkOutput("LoadSplice", 32'(LoadSplice), trace[i].spl);
      if (trace[i].spl >= 0 && trace[i].st == ST_STORE)
        checkOutput("StoreSplice", 32'(StoreSplice), trace[i].spl);
      if (trace[i].cause >= 0) begin
        checkOutput("IntCause", 32'(IntCause), trace[i].cause);
        checkOutput("EPCWrite", 32'(EPCWrite), 1);
      end
      if (trace[i].st == ST_EXC_WAIT && trace[i].pcws)
        checkOutput("PCSource_exc", 32'(PCSource), 2);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_state"}, 32'(state_out), 0);
    checkOutput({tag, "_ALUOp"}, 32'(ALUOp), A_SUM);
    checkOutput({tag, "_strobes"},
                32'({PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA,
                     ALUSrcB, MemToReg, LoadSplice, StoreSplice, LoadAOut,
                     RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR, IMemRead,
                     IRWrite, IntCause, CauseWrite, EPCWrite, DataMemSrc,
                     Halted}), 0);
  endtask

  // Releases reset between edges and walks START into the first FETCH.
  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkIdle("start");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    int          sel;
    reset = 1'b1;
    applyStimulus(32'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    releaseReset();

    // Directed cases
    runInstr(32'h00500093, 0, 0, 0, 0, 99);
    runInstr(32'h0040a083, 0, 0, 0, 0, 99);
    runInstr(32'h00208463, 1, 0, 0, 0, 99);
    runInstr(32'h00208463, 0, 1, 0, 0, 99);
    runInstr(32'h0020d463, 1, 0, 0, 0, 99);
    runInstr(32'h0000007f, 0, 0, 0, 0, 99);
    runInstr(32'h00200073, 0, 0, 0, 0, 99);
    runInstr(32'h002081b3, 0, 0, 0, 1, 99);
    runInstr(32'h00508093, 0, 0, 0, 1, 99);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 10);
      case (sel)
        0: ins[6:0] = 7'h03;
        1: ins[6:0] = 7'h23;
        2, 10: begin
          ins[6:0] = 7'h13;
          if ($urandom_range(0, 1) == 1) ins[31:26] = 6'b010000;
        end
        3: begin
          ins[6:0] = 7'h33;
          if ($urandom_range(0, 1) == 1) ins[14:12] = 3'd0;
        end
        4: ins[6:0] = 7'h37;
        5: ins[6:0] = 7'h63;
        6: ins[6:0] = 7'h6f;
        7: ins[6:0] = 7'h67;
        8: begin
          ins[6:0] = 7'h73;
          if (ins == 32'h00100073) ins[31] = 1'b1;
        end
        default: ins[6:0] = ($urandom_range(0, 1) == 1) ? 7'h7f : 7'h0f;
      endcase
      runInstr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 99);
    end

    // Reset asserted in the middle of EXC_WAIT drops everything at once
    runInstr(32'h0000007f, 0, 0, 0, 0, 5);
    #1;
    checkOutput("midwait_state", 32'(state_out), ST_EXC_WAIT);
    checkOutput("midwait_DataMemSrc", 32'(DataMemSrc), 1);
    reset = 1'b1;
    #1;
    checkIdle("midreset");
    @(posedge clk);
    #1;
    checkIdle("heldreset");
    releaseReset();

    // Halt is sticky
    runInstr(32'h00100073, 0, 0, 0, 0, 99);
    for (int c = 0; c < 22; c++) begin
      applyStimulus($urandom, 1'($urandom_range(0, 1)), 0, 0, 0);
      #1;
      checkOutput("halt_state", 32'(state_out), ST_HALT);
      checkOutput("halt_Halted", 32'(Halted), 1);
      checkOutput("halt_strobes", 32'({PCWriteState, IMemRead, RegWrite, DMemOp}), 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checkIdle("haltreset");
    releaseReset();
    runInstr(32'h00500093, 0, 0, 0, 0, 99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
